reorder_buffer: RTL

In-order retirement buffer for the out-of-order core. Dispatch allocates one entry per instruction in program order and receives the entry's tag, which travels with the op through the execution buffer and ALU. Writeback marks entries complete, out of order, by tag. The head entry retires in program order, at most one per cycle, and drives the architectural register write.

---
 rtl/reorder_buffer_if.sv | 43 ++++
 rtl/reorder_buffer.sv | 111 +++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// Dispatch / writeback / retire bundle between the core and the reorder buffer.
`ifndef NUM_D_REG
`define NUM_D_REG 8
`endif

interface reorder_buffer_if #(
  parameter int unsigned L = 8
);
  localparam int unsigned AW = $clog2(L);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = $clog2(`NUM_D_REG);

  logic          flush;
  logic          alloc_valid;
  logic          alloc_ready;
  logic          alloc_writes;
  logic [RW-1:0] alloc_rw_addr;
  logic [AW-1:0] alloc_rob_addr;
  logic          complete_valid;
  logic [AW-1:0] complete_rob_addr;
  logic [15:0]   complete_data;
  logic          retire_valid;
  logic          retire_writes;
  logic [RW-1:0] retire_rw_addr;
  logic [15:0]   retire_data;
  logic [CW-1:0] count;

  // Core side: dispatch, writeback and flush sources; retire consumer.
  modport master (
    output flush, alloc_valid, alloc_writes, alloc_rw_addr,
           complete_valid, complete_rob_addr, complete_data,
    input  alloc_ready, alloc_rob_addr, retire_valid, retire_writes,
           retire_rw_addr, retire_data, count
  );

  // Reorder buffer side.
  modport slave (
    input  flush, alloc_valid, alloc_writes, alloc_rw_addr,
           complete_valid, complete_rob_addr, complete_data,
    output alloc_ready, alloc_rob_addr, retire_valid, retire_writes,
           retire_rw_addr, retire_data, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete by tag, retire from head.
`ifndef NUM_D_REG
`define NUM_D_REG 8
`endif

module reorder_buffer #(
  parameter int unsigned L = 8
) (
  input logic             clk,
  input logic             n_rst,
  reorder_buffer_if.slave rob
);
  localparam int unsigned AW = $clog2(L);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = $clog2(`NUM_D_REG);

  logic [L-1:0]  valid_q, valid_d;
  logic [L-1:0]  done_q, done_d;
  logic [L-1:0]  writes_q, writes_d;
  logic [RW-1:0] rw_addr_q [L];
  logic [RW-1:0] rw_addr_d [L];
  logic [15:0]   data_q [L];
  logic [15:0]   data_d [L];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic not_full;
  logic alloc_fire;
  logic complete_fire;
  logic retire_fire;

  // Handshake qualifiers; completion only lands on an entry that was already live.
  assign not_full      = (count_q != CW'(L));
  assign alloc_fire    = rob.alloc_valid & not_full;
  assign complete_fire = rob.complete_valid & valid_q[rob.complete_rob_addr];
  assign retire_fire   = valid_q[head_q] & done_q[head_q];

  // Outputs are taken straight from registered state.
  assign rob.alloc_ready    = not_full;
  assign rob.alloc_rob_addr = tail_q;
  assign rob.retire_valid   = retire_fire;
  assign rob.retire_writes  = writes_q[head_q];
  assign rob.retire_rw_addr = rw_addr_q[head_q];
  assign rob.retire_data    = data_q[head_q];
  assign rob.count          = count_q;

  // Next state: flush dominates; otherwise complete, retire and allocate in parallel.
  always_comb begin
    valid_d   = valid_q;
    done_d    = done_q;
    writes_d  = writes_q;
    rw_addr_d = rw_addr_q;
    data_d    = data_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (rob.flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (complete_fire) begin
        done_d[rob.complete_rob_addr] = 1'b1;
        data_d[rob.complete_rob_addr] = rob.complete_data;
      end
      if (retire_fire) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + AW'(1);
      end
      // Tail never aliases a live entry while allocation is permitted.
      if (alloc_fire) begin
        valid_d[tail_q]   = 1'b1;
        done_d[tail_q]    = 1'b0;
        writes_d[tail_q]  = rob.alloc_writes;
        rw_addr_d[tail_q] = rob.alloc_rw_addr;
        tail_d            = tail_q + AW'(1);
      end
      count_d = count_q + CW'(alloc_fire) - CW'(retire_fire);
    end
  end

  // State registers with asynchronous clear of control and payload.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q  <= '0;
      done_q   <= '0;
      writes_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(L); i++) begin
        rw_addr_q[i] <= '0;
        data_q[i]    <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      done_q    <= done_d;
      writes_q  <= writes_d;
      rw_addr_q <= rw_addr_d;
      data_q    <= data_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end
endmodule
